addsub_share_arb: RTL

//  Shares one 16-bit saturating add/sub datapath (cla_16bit) among NUM_REQ requesters.

---
 rtl/addsub_share_arb.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/addsub_share_arb.sv
// Round-robin (or fixed-priority with ADDSUB_FIXED_PRIO_EN) arbiter sharing one
// saturating 16-bit add/sub datapath among NUM_REQ requesters, registered result.
module cla_16bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum
);
    logic [15:0] w_p;
    logic [15:0] w_g;
    logic [15:0] w_c;
    logic [2:0]  w_gp;
    logic [2:0]  w_gg;
    logic [3:0]  w_gc;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Two-level lookahead: group carries first, then ripple within 4-bit groups
    always_comb begin
        w_gc    = '0;
        w_gc[0] = i_cin;
        w_gp    = '0;
        w_gg    = '0;
        for (int j = 0; j < 3; j++) begin
            w_gp[j] = &w_p[4*j +: 4];
            w_gg[j] = w_g[4*j+3]
                    | (w_p[4*j+3] & w_g[4*j+2])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
            w_gc[j+1] = w_gg[j] | (w_gp[j] & w_gc[j]);
        end
    end

    always_comb begin
        w_c = '0;
        for (int j = 0; j < 4; j++) begin
            w_c[4*j] = w_gc[j];
            for (int k = 0; k < 3; k++) begin
                w_c[4*j+k+1] = w_g[4*j+k] | (w_p[4*j+k] & w_c[4*j+k]);
            end
        end
    end

    assign o_sum = w_p ^ w_c;
endmodule

module addsub_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    input  logic [NUM_REQ-1:0]      req_sub,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [IDW-1:0]          resp_id,
    output logic [15:0]             resp_sum,
    output logic                    resp_ovfl
);
    logic               r_valid;
    logic [IDW-1:0]     r_id;
    logic [15:0]        r_sum;
    logic               r_ovfl;

    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [IDW-1:0]     w_gnt_idx;
    logic               w_found;
    logic               w_can_accept;
    logic               w_accept;
    logic [15:0]        w_a;
    logic [15:0]        w_b;
    logic               w_sub;
    logic [15:0]        w_b_eff;
    logic [15:0]        w_raw;
    logic               w_ovfl;
    logic [15:0]        w_res;

`ifdef ADDSUB_FIXED_PRIO_EN
    always_comb begin
        w_gnt_oh  = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !w_found) begin
                w_found     = 1'b1;
                w_gnt_oh[i] = 1'b1;
                w_gnt_idx   = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] r_rr_ptr;

    // Pass one covers indices above the pointer, pass two wraps to the rest
    always_comb begin
        w_gnt_oh  = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !w_found && (i > int'(r_rr_ptr))) begin
                w_found     = 1'b1;
                w_gnt_oh[i] = 1'b1;
                w_gnt_idx   = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !w_found && (i <= int'(r_rr_ptr))) begin
                w_found     = 1'b1;
                w_gnt_oh[i] = 1'b1;
                w_gnt_idx   = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= IDW'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_rr_ptr <= w_gnt_idx;
        end
    end
`endif

    assign w_can_accept = ~r_valid | resp_ready;
    assign req_ready    = (rst_n && w_can_accept) ? w_gnt_oh : '0;
    assign w_accept     = |(req_valid & req_ready);

    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_sub = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_oh[i]) begin
                w_a   = req_a[16*i +: 16];
                w_b   = req_b[16*i +: 16];
                w_sub = req_sub[i];
            end
        end
    end

    assign w_b_eff = w_sub ? ~w_b : w_b;

    cla_16bit u_cla (
        .i_a   (w_a),
        .i_b   (w_b_eff),
        .i_cin (w_sub),
        .o_sum (w_raw)
    );

    // Comparing against the effective B covers both the add and sub rules
    assign w_ovfl = (w_a[15] == w_b_eff[15]) && (w_raw[15] != w_a[15]);
    assign w_res  = !w_ovfl ? w_raw : (w_a[15] ? 16'h8000 : 16'h7FFF);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_sum   <= '0;
            r_ovfl  <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_id    <= w_gnt_idx;
            r_sum   <= w_res;
            r_ovfl  <= w_ovfl;
        end else if (resp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign resp_valid = r_valid;
    assign resp_id    = r_id;
    assign resp_sum   = r_sum;
    assign resp_ovfl  = r_ovfl;
endmodule
